// File: rtl/rr_arbiter8_pkg.sv
// arb_pkg: shared sizing constants and arbiter state encoding.
package arb_pkg;
   localparam int ARB_N        = 8;
   localparam int ARB_IDXW     = 3;
   localparam int ARB_MAX_HOLD = 16;
   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
endpackage

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between requesters (master) and arbiter (slave).
interface rr_arbiter8_if import arb_pkg::*; #(
   parameter int N    = ARB_N,
   parameter int IDXW = ARB_IDXW
);
   logic [N-1:0]    req;
   logic            done;
   logic [N-1:0]    gnt;
   logic [IDXW-1:0] gnt_idx;
   logic            gnt_valid;
   logic            preempt;
   modport master (output req, done, input gnt, gnt_idx, gnt_valid, preempt);
   modport slave  (input req, done, output gnt, gnt_idx, gnt_valid, preempt);
endinterface

// File: rtl/onehot_enc8.sv
// onehot_enc8: 8-bit one-hot to 3-bit index; all-zero input yields 0.
module onehot_enc8 (
   input  logic [7:0] oh,
   output logic [2:0] idx
);
   always_comb begin
      idx = '0;
      for (int i = 0; i < 8; i++)
         if (oh[i]) idx = idx | 3'(i);
   end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter with registered one-hot grant, release on
// drop/done, and preemption after MAX_HOLD contended cycles.
module rr_arbiter8 import arb_pkg::*; #(
   parameter int N        = ARB_N,
   parameter int IDXW     = ARB_IDXW,
   parameter int MAX_HOLD = ARB_MAX_HOLD
) (
   input logic          clk,
   input logic          rst_n,
   rr_arbiter8_if.slave bus
);
   localparam int HW = $clog2(MAX_HOLD);

   arb_state_e      state_q, state_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic            preempt_q, preempt_d;
   logic [IDXW-1:0] h, pick;
   logic            tmo, rel;

   function automatic logic [IDXW-1:0] rr_pick(input logic [N-1:0] r, input logic [IDXW-1:0] p);
      logic [IDXW-1:0] idx;
      logic            hit;
      rr_pick = p;
      hit     = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = p + IDXW'(k);
         if (r[idx] && !hit) begin
            rr_pick = idx;
            hit     = 1'b1;
         end
      end
   endfunction

   onehot_enc8 u_enc (.oh(gnt_q), .idx(h));

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = h;
   assign bus.gnt_valid = |gnt_q;
   assign bus.preempt   = preempt_q;

   always_comb begin
      pick      = rr_pick(bus.req, ptr_q);
      tmo       = hold_q == HW'(MAX_HOLD - 1);
      rel       = !bus.req[h] || bus.done || (tmo && |(bus.req & ~gnt_q));
      state_d   = state_q;
      gnt_d     = gnt_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      preempt_d = 1'b0;
      if (state_q == ARB_IDLE) begin
         if (|bus.req) begin
            state_d = ARB_GRANT;
            gnt_d   = N'(1) << pick;
            hold_d  = '0;
         end
      end else if (rel) begin
         state_d   = ARB_IDLE;
         gnt_d     = '0;
         ptr_d     = h + 1'b1;
         hold_d    = '0;
         // only a timeout release can leave the holder still requesting without done
         preempt_d = bus.req[h] && !bus.done;
      end else begin
         hold_d = tmo ? '0 : hold_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ARB_IDLE;
         gnt_q     <= '0;
         ptr_q     <= '0;
         hold_q    <= '0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         preempt_q <= preempt_d;
      end
   end
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed scenario tasks with hand-computed expected grants.
module tb_rr_arbiter8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   rr_arbiter8_if bus ();
   rr_arbiter8 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.req  = '0;
      bus.done = 1'b0;
      rst_n    = 1'b0;
      tick();
      tick();
      n_chk++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL reset_gnt got %h want 00", bus.gnt); end
      n_chk++; if (bus.gnt_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", bus.gnt_idx); end
      n_chk++; if (bus.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.gnt_valid); end
      n_chk++; if (bus.preempt !== 1'b0) begin n_fail++; $display("FAIL reset_preempt got %b want 0", bus.preempt); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      bus.req = 8'h01;
      tick();
      n_chk++; if (bus.gnt !== 8'h01) begin n_fail++; $display("FAIL basic_gnt got %h want 01", bus.gnt); end
      n_chk++; if (bus.gnt_idx !== 3'd0) begin n_fail++; $display("FAIL basic_idx got %0d want 0", bus.gnt_idx); end
      n_chk++; if (bus.gnt_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", bus.gnt_valid); end
      bus.req = 8'h00;
      tick();
      n_chk++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL basic_release got %h want 00", bus.gnt); end
      n_chk++; if (bus.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_release_valid got %b want 0", bus.gnt_valid); end
      bus.req = 8'h03;
      tick();
      n_chk++; if (bus.gnt_idx !== 3'd1) begin n_fail++; $display("FAIL basic_ptr1 got %0d want 1", bus.gnt_idx); end
      bus.req = 8'h00;
      tick();
   endtask

   task automatic test_walk();
      for (int i = 0; i < 8; i++) begin
         bus.req = 8'(1 << i);
         tick();
         n_chk++; if (bus.gnt_idx !== 3'(i)) begin n_fail++; $display("FAIL walk_idx got %0d want %0d", bus.gnt_idx, i); end
         n_chk++; if (bus.gnt !== 8'(1 << i)) begin n_fail++; $display("FAIL walk_gnt got %h want %h", bus.gnt, 8'(1 << i)); end
         tick();
         tick();
         n_chk++; if (bus.gnt_idx !== 3'(i)) begin n_fail++; $display("FAIL walk_hold got %0d want %0d", bus.gnt_idx, i); end
         bus.req = 8'h00;
         tick();
         n_chk++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL walk_idle got %h want 00", bus.gnt); end
      end
   endtask

   task automatic test_contention();
      bus.req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         tick();
         n_chk++; if (bus.gnt_idx !== 3'(k % 8) || bus.gnt_valid !== 1'b1) begin n_fail++; $display("FAIL rr_order got %0d/%b want %0d/1", bus.gnt_idx, bus.gnt_valid, k % 8); end
         tick();
         n_chk++; if (bus.gnt !== 8'(1 << (k % 8))) begin n_fail++; $display("FAIL rr_hold got %h want %h", bus.gnt, 8'(1 << (k % 8))); end
         bus.done = 1'b1;
         tick();
         bus.done = 1'b0;
         n_chk++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL rr_gap got %h want 00", bus.gnt); end
      end
      bus.req = 8'h00;
      tick();
   endtask

   task automatic test_timeout();
      bus.req = 8'h80;
      tick();
      bus.req = 8'h00;
      tick();
      bus.req = 8'h03;
      tick();
      n_chk++; if (bus.gnt !== 8'h01) begin n_fail++; $display("FAIL tmo_first got %h want 01", bus.gnt); end
      for (int c = 2; c <= 16; c++) begin
         tick();
         n_chk++; if (bus.gnt !== 8'h01 || bus.preempt !== 1'b0) begin n_fail++; $display("FAIL tmo_hold cycle %0d got %h/%b want 01/0", c, bus.gnt, bus.preempt); end
      end
      tick();
      n_chk++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL tmo_revoke got %h want 00", bus.gnt); end
      n_chk++; if (bus.preempt !== 1'b1) begin n_fail++; $display("FAIL tmo_preempt got %b want 1", bus.preempt); end
      tick();
      n_chk++; if (bus.gnt_idx !== 3'd1 || bus.preempt !== 1'b0) begin n_fail++; $display("FAIL tmo_next got %0d/%b want 1/0", bus.gnt_idx, bus.preempt); end
      bus.req = 8'h00;
      tick();
      bus.req = 8'h01;
      tick();
      for (int c = 0; c < 40; c++) begin
         tick();
         n_chk++; if (bus.gnt !== 8'h01 || bus.preempt !== 1'b0) begin n_fail++; $display("FAIL solo_hold cycle %0d got %h/%b want 01/0", c, bus.gnt, bus.preempt); end
      end
      bus.req = 8'h00;
      tick();
      n_chk++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL solo_release got %h want 00", bus.gnt); end
   endtask

   task automatic test_simultaneous();
      bus.req = 8'h03;
      tick();
      n_chk++; if (bus.gnt !== 8'h02) begin n_fail++; $display("FAIL sim_grant got %h want 02", bus.gnt); end
      for (int c = 2; c <= 16; c++) tick();
      n_chk++; if (bus.gnt !== 8'h02) begin n_fail++; $display("FAIL sim_hold got %h want 02", bus.gnt); end
      bus.done = 1'b1;
      tick();
      n_chk++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL sim_release got %h want 00", bus.gnt); end
      n_chk++; if (bus.preempt !== 1'b0) begin n_fail++; $display("FAIL sim_preempt got %b want 0", bus.preempt); end
      bus.req = 8'h00;
      tick();
      n_chk++; if (bus.gnt !== 8'h00 || bus.preempt !== 1'b0) begin n_fail++; $display("FAIL idle_done got %h/%b want 00/0", bus.gnt, bus.preempt); end
      bus.done = 1'b0;
      bus.req  = 8'h01;
      tick();
      n_chk++; if (bus.gnt !== 8'h01) begin n_fail++; $display("FAIL idle_done_next got %h want 01", bus.gnt); end
      bus.req = 8'h00;
      tick();
   endtask

   task automatic test_async_reset();
      bus.req = 8'h10;
      tick();
      n_chk++; if (bus.gnt !== 8'h10) begin n_fail++; $display("FAIL ar_grant got %h want 10", bus.gnt); end
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL ar_clear got %h/%b want 00/0", bus.gnt, bus.gnt_valid); end
      bus.req = 8'h00;
      tick();
      #2 rst_n = 1'b1;
      bus.req = 8'h81;
      tick();
      if (!bus.gnt_valid) tick();
      n_chk++; if (bus.gnt_idx !== 3'd0 || bus.gnt_valid !== 1'b1) begin n_fail++; $display("FAIL ar_ptr0 got %0d/%b want 0/1", bus.gnt_idx, bus.gnt_valid); end
      bus.req = 8'h00;
      tick();
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      bus.req = 8'h80;
      tick();
      if (!bus.gnt_valid) tick();
      n_chk++; if (bus.gnt_idx !== 3'd7 || bus.gnt !== 8'h80) begin n_fail++; $display("FAIL ar_first got %0d/%h want 7/80", bus.gnt_idx, bus.gnt); end
      bus.req = 8'h00;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_walk();
      test_contention();
      test_timeout();
      test_simultaneous();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter sharing a single resource among 8 requesters, producing a registered one-hot grant and its 3-bit encoded index. It sits ahead of the 8-to-3 encoder path. Its grant vector is always one-hot or zero, so the encoder's output is always meaningful. Grants are held until release or timeout, and priority rotates past the last holder for fairness.

## Interface
- N, default 8: number of requesters; fixed at 8 for this revision.
- IDXW, default 3: index width, equal to log2(N).
- MAX_HOLD, default 16: maximum consecutive grant cycles before preemption; must be ≥ 2.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N  request vector; bit i is requester i and is level-sensitive.
- done  in  1  single-cycle release pulse from the current holder.
- gnt  out  N  registered grant, one-hot or all-zero.
- gnt_idx  out  IDXW  encoded index of the holder; 0 when gnt_valid is 0.
- gnt_valid  out  1  high whenever gnt is non-zero.
- preempt  out  1  single-cycle pulse when a grant is revoked by timeout.

## Operation
- Reset values: all outputs are 0, ptr=0, hold_cnt=0, state=IDLE.
- ptr (IDXW bits) is the highest-priority requester. Search order is ptr, ptr+1, … ptr+N-1, modulo N.

IDLE state:
- If req is non-zero, select the first set bit in search order.
- Load gnt with the one-hot of that bit, set hold_cnt=0, and go to GRANT.
- If req is zero, stay in IDLE with outputs at 0.

GRANT state:
- hold_cnt increments each cycle. Let h be the current holder.
- Release on the first true condition, in this order:
  - (a) req[h]==0
  - (b) done==1
  - (c) hold_cnt==MAX_HOLD-1 and some other req bit is set; pulse preempt=1 for that cycle.
- On release: clear gnt, set ptr=(h+1) mod N (wrap 7→0), and return to IDLE.
- If hold_cnt==MAX_HOLD-1 and no other requester is pending, do not revoke. Reset hold_cnt to 0 and keep the grant.
- done arriving in IDLE is ignored.
- req bits other than h are ignored during GRANT, except for the preemption check.
- When done and timeout occur in the same cycle, the release is counted as done, and preempt stays 0.

Output derivation:
- gnt_idx is the encoded value of gnt, produced by the encoder sub-module from the gnt register, so it is registered-equivalent.
- gnt_valid = |gnt.

## Timing
- Grant latency: req sampled high at edge t gives gnt at edge t+1, provided the arbiter is in IDLE.
- Release latency: a release condition sampled at edge t clears gnt at edge t+1.
- One mandatory idle cycle separates consecutive grants. Minimum period per grant is 2 cycles.
- A holder keeps the grant for at most MAX_HOLD cycles when contended.
- Worst-case wait for any requester is 7×(MAX_HOLD+1) cycles.
- Asynchronous reset mid-grant clears gnt immediately, without waiting for a clock edge. After deassertion, the first grant can appear on the second rising edge.
- No combinational path from req or done to any output.

## Structure
- Shared package arb_pkg holds:
  - ARB_N=8, ARB_IDXW=3, ARB_MAX_HOLD=16
  - state enum {ARB_IDLE, ARB_GRANT}
- One sub-module, onehot_enc8: 8-bit one-hot in, 3-bit index out, purely combinational (index i for bit i). It is instantiated on gnt.
- Rotating priority search is a local function in the arbiter, not a separate module.

## Test plan
- Reset, then req=8'h01 → gnt=8'h01, gnt_idx=0, gnt_valid=1 one cycle later. Drop req → gnt=0 next cycle, ptr=1.
- Walking single request: req = 1<<i for i=0..7, each held 3 cycles → gnt_idx=i every time, one idle cycle between grants.
- Contention: req=8'hFF held, done pulsed every 2nd grant cycle → grant order 0,1,2,…,7,0, with a wrap from 7 to 0.
- Timeout: req=8'h03 held, no done → requester 0 holds 16 cycles, preempt=1 on cycle 16, then gnt_idx=1. Repeat with req=8'h01 alone → no preempt, grant held indefinitely.
- Simultaneous events: done and timeout in the same cycle → release with preempt=0. done in IDLE → no effect.
- Async reset mid-grant: assert rst_n=0 between edges while gnt=8'h10 → gnt=0, gnt_valid=0 immediately. After release, req=8'h80 → gnt_idx=7, since ptr restarted at 0.
